mem_request_unit: RTL

Parametrised successor to the datapath request unit. It sequences instruction and data memory requests for the CPU datapath and sits between the control unit and the cache ports. It latches data requests until `dhit`, gates PC writes, and supports an optional overlapped-fetch mode. It also drains cleanly on `halt` and raises a sticky watchdog error when memory stops answering.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/request_pkg.sv | 9 +
 rtl/mem_request_unit_if.sv | 16 +
 rtl/ru_watchdog.sv | 31 +++
 rtl/mem_request_unit.sv | 95 +++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide types shared by the datapath blocks.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/request_pkg.sv
// Shared definitions for the memory request unit.
package request_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {IDLE, DREQ, HALTED, ERR} ru_state_t;

    localparam int WD_W_DEFAULT   = 8;
    localparam int WD_MAX_DEFAULT = 200;
endpackage

// File: rtl/mem_request_unit_if.sv
// Control-unit / cache-port bundle around mem_request_unit.
// Handshake: a data request (dmemREN/dmemWEN) is held from the edge after the
// decoding ihit until the edge after dhit; dhit acts as the ready for that request.
interface mem_request_unit_if;
    logic halt, dREN, dWEN, ihit, dhit;
    logic dmemREN, dmemWEN, imemREN, pcWEN, stall, halted, timeout;

    modport ru (
        input  halt, dREN, dWEN, ihit, dhit,
        output dmemREN, dmemWEN, imemREN, pcWEN, stall, halted, timeout
    );
    modport tb (
        output halt, dREN, dWEN, ihit, dhit,
        input  dmemREN, dmemWEN, imemREN, pcWEN, stall, halted, timeout
    );
endinterface

// File: rtl/ru_watchdog.sv
// Saturating wait counter for outstanding data requests.
module ru_watchdog #(
    parameter int WD_W   = 8,
    parameter int WD_MAX = 200
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired,
    output logic expiring
);
    localparam logic [WD_W-1:0] MAX_C  = WD_W'(WD_MAX);
    localparam logic [WD_W-1:0] LAST_C = WD_W'(WD_MAX - 1);

    logic [WD_W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WD_W'(1);
        end
    end

    assign expired  = (count == MAX_C);
    // High in the cycle whose increment will land exactly on WD_MAX.
    assign expiring = en && !clr && (count == LAST_C);
endmodule

// File: rtl/mem_request_unit.sv
// Sequences instruction/data memory requests, gates PC writes, handles halt
// and a watchdog timeout on unanswered data requests.
module mem_request_unit
    import request_pkg::*;
#(
    parameter bit PIPELINED = 1'b0,
    parameter int WD_W      = WD_W_DEFAULT,
    parameter int WD_MAX    = WD_MAX_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      halt,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      ihit,
    input  logic      dhit,
    output logic      dmemREN,
    output logic      dmemWEN,
    output logic      imemREN,
    output logic      pcWEN,
    output logic      stall,
    output logic      halted,
    output logic      timeout,
    output ru_state_t state
);
    logic data_op;
    logic start_req;
    logic wd_en;
    logic wd_expired;
    logic wd_last;

    assign data_op   = dREN || dWEN;
    assign start_req = (state == IDLE) && !halt && ihit && data_op;
    assign wd_en     = (state == DREQ) && !dhit;

    ru_watchdog #(
        .WD_W   (WD_W),
        .WD_MAX (WD_MAX)
    ) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr      (start_req),
        .en       (wd_en),
        .expired  (wd_expired),
        .expiring (wd_last)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (ihit && data_op) begin
                        state   <= DREQ;
                        dmemWEN <= dWEN;
                        dmemREN <= dREN && !dWEN;
                    end
                end
                DREQ: begin
                    // dhit beats a simultaneous watchdog expiry.
                    if (dhit) begin
                        state   <= halt ? HALTED : IDLE;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end else if (wd_last || wd_expired) begin
                        state   <= ERR;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        pcWEN = 1'b0;
        case (state)
            IDLE:    pcWEN = ihit && !halt && !data_op;
            DREQ:    pcWEN = dhit;
            default: pcWEN = 1'b0;
        endcase
    end

    assign imemREN = (state == IDLE) || ((state == DREQ) && PIPELINED);
    assign stall   = (state == DREQ);
    assign halted  = (state == HALTED);
    assign timeout = (state == ERR);
endmodule
